// File: rtl/prescaler_multi_if.sv
// Bus bundle for the multi-channel prescaler: per-channel control and
// settings driven by the master side, divided clocks and status returned.
interface prescaler_multi_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 28
);

  logic [NCH-1:0]       en;
  logic                 sync;
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] period_in;
  logic [NCH*WIDTH-1:0] high_in;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       pending;

  modport master (
    output en,
    output sync,
    output load,
    output period_in,
    output high_in,
    input  clk_out,
    input  tick,
    input  pending
  );

  modport slave (
    input  en,
    input  sync,
    input  load,
    input  period_in,
    input  high_in,
    output clk_out,
    output tick,
    output pending
  );

endinterface

// File: rtl/prescaler_multi.sv
// Multi-channel clock prescaler. Each channel divides the system clock by a
// programmable ratio P with a programmable high time H. New settings wait in
// a shadow register and are only applied at a period boundary (or while the
// channel is idle), so the divided clocks never glitch. A shared sync pulse
// restarts every running channel at count 0 to phase-align them.
module prescaler_multi #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 28,
  parameter int RESET_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  prescaler_multi_if.slave io_bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO  = '0;
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] C_RST_P = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] C_RST_H = WIDTH'(RESET_DIV / 2);

  logic [NCH-1:0] w_clkOut;
  logic [NCH-1:0] w_tick;
  logic [NCH-1:0] w_pending;

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch

    logic [WIDTH-1:0] w_periodIn;
    logic [WIDTH-1:0] w_highIn;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_actP;
    logic [WIDTH-1:0] r_actH;
    logic [WIDTH-1:0] r_shP;
    logic [WIDTH-1:0] r_shH;
    logic             r_pending;
    logic             r_clkOut;
    logic             r_tick;

    logic             w_wrap;
    logic             w_boundary;
    logic             w_apply;
    logic [WIDTH-1:0] w_nextP;
    logic [WIDTH-1:0] w_nextH;
    logic             w_curValid;
    logic             w_nextValid;
    logic [WIDTH-1:0] w_cntInc;
    logic [WIDTH-1:0] w_lastCnt;

    assign w_periodIn = io_bus.period_in[g*WIDTH +: WIDTH];
    assign w_highIn   = io_bus.high_in[g*WIDTH +: WIDTH];

    // The active P is at least 2 whenever the channel runs, so P-1 never
    // underflows there and cnt+1 never overflows because cnt stays below P-1
    // on the non-wrapping path.
    assign w_lastCnt  = r_actP - C_ONE;
    assign w_wrap     = (r_cnt == w_lastCnt);
    assign w_boundary = w_wrap || io_bus.sync;
    assign w_cntInc   = r_cnt + C_ONE;

    // An idle channel takes its shadow on any edge; a running one only at a
    // period boundary, so a half-finished period is never cut short.
    assign w_apply     = r_pending && ((r_state == ST_IDLE) || w_boundary);
    assign w_nextP     = w_apply ? r_shP : r_actP;
    assign w_nextH     = w_apply ? r_shH : r_actH;
    assign w_curValid  = (r_actP >= C_TWO);
    assign w_nextValid = (w_nextP >= C_TWO);

    // Per-channel state machine: shadow/apply bookkeeping, counter and the
    // registered clk_out/tick, all in one clocked block.
    always_ff @(posedge clock) begin
      if (!reset) begin
        r_state   <= ST_IDLE;
        r_cnt     <= C_ZERO;
        r_actP    <= C_RST_P;
        r_actH    <= C_RST_H;
        r_shP     <= C_RST_P;
        r_shH     <= C_RST_H;
        r_pending <= 1'b0;
        r_clkOut  <= 1'b0;
        r_tick    <= 1'b0;
      end else begin
        if (w_apply) begin
          r_actP    <= r_shP;
          r_actH    <= r_shH;
          r_pending <= 1'b0;
        end
        // A load on the same edge as an apply wins the pending flag: the
        // apply consumed the old shadow, the new values still wait.
        if (io_bus.load[g]) begin
          r_shP     <= w_periodIn;
          r_shH     <= w_highIn;
          r_pending <= 1'b1;
        end

        case (r_state)
          ST_IDLE: begin
            r_cnt  <= C_ZERO;
            r_tick <= 1'b0;
            if (io_bus.en[g] && w_curValid && w_nextValid) begin
              r_state  <= ST_RUN;
              r_clkOut <= (w_nextH != C_ZERO);
            end else begin
              r_state  <= ST_IDLE;
              r_clkOut <= 1'b0;
            end
          end

          ST_RUN: begin
            if (!io_bus.en[g]) begin
              r_state  <= ST_IDLE;
              r_cnt    <= C_ZERO;
              r_clkOut <= 1'b0;
              r_tick   <= 1'b0;
            end else if (w_boundary) begin
              r_cnt  <= C_ZERO;
              r_tick <= 1'b0;
              if (!w_nextValid) begin
                r_state  <= ST_IDLE;
                r_clkOut <= 1'b0;
              end else begin
                r_state  <= ST_RUN;
                r_clkOut <= (w_nextH != C_ZERO);
              end
            end else begin
              r_state  <= ST_RUN;
              r_cnt    <= w_cntInc;
              r_clkOut <= (w_cntInc < r_actH);
              r_tick   <= (w_cntInc == w_lastCnt);
            end
          end

          default: begin
            r_state  <= ST_IDLE;
            r_cnt    <= C_ZERO;
            r_clkOut <= 1'b0;
            r_tick   <= 1'b0;
          end
        endcase
      end
    end

    assign w_clkOut[g]  = r_clkOut;
    assign w_tick[g]    = r_tick;
    assign w_pending[g] = r_pending;

  end : g_ch

  assign io_bus.clk_out = w_clkOut;
  assign io_bus.tick    = w_tick;
  assign io_bus.pending = w_pending;

endmodule

// File: tb/tb_prescaler_multi.sv
// Self-checking bench for prescaler_multi: a phase-based behavioural model
// is compared every cycle, and directed scenarios pin hand-computed patterns.
module tb_prescaler_multi;

  localparam int NCH  = 4;
  localparam int W    = 28;
  localparam int RDIV = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  prescaler_multi_if #(.NCH(NCH), .WIDTH(W)) bus ();

  prescaler_multi #(
    .NCH      (NCH),
    .WIDTH    (W),
    .RESET_DIV(RDIV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io_bus(bus)
  );

  // Free-running system clock.
  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: whether the channel runs, its position within the period,
  // the active and shadow settings and the pending flag.
  bit          mRun  [NCH];
  int unsigned mPh   [NCH];
  int unsigned mP    [NCH];
  int unsigned mH    [NCH];
  int unsigned mSP   [NCH];
  int unsigned mSH   [NCH];
  bit          mPend [NCH];
  bit          modelValid = 1'b0;

  task automatic checkOutput(input string name, input logic [NCH-1:0] actual,
                             input logic [NCH-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {{(NCH-1){1'b0}}, actual}, {{(NCH-1){1'b0}}, expected});
  endtask

  task automatic expectWait(input string name, input bit ok);
    assertCount++;
    if (!ok) begin
      failCount++;
      $display("[TB] FAIL %s: wait bound expired, got timeout expected event", name);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic setLoad(input int c, input int unsigned p, input int unsigned h);
    bus.period_in[c*W +: W] = W'(p);
    bus.high_in[c*W +: W]   = W'(h);
    bus.load[c]             = 1'b1;
  endtask

  // Model update: advance each channel's phase by the rules for start,
  // stop, wrap, sync and deferred application of the shadow settings.
  always @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        mRun[c]  = 1'b0;
        mPh[c]   = 0;
        mP[c]    = RDIV;
        mH[c]    = RDIV / 2;
        mSP[c]   = RDIV;
        mSH[c]   = RDIV / 2;
        mPend[c] = 1'b0;
      end
      modelValid = 1'b1;
    end else if (modelValid) begin
      for (int c = 0; c < NCH; c++) begin
        bit          eop;
        bit          app;
        bit          go;
        int unsigned nP;
        int unsigned nH;
        eop = mRun[c] && ((mPh[c] == mP[c] - 1) || bus.sync);
        app = mPend[c] && (!mRun[c] || eop);
        nP  = app ? mSP[c] : mP[c];
        nH  = app ? mSH[c] : mH[c];
        if (!mRun[c]) begin
          go     = bus.en[c] && (mP[c] >= 2) && (nP >= 2);
          mPh[c] = 0;
        end else if (!bus.en[c]) begin
          go     = 1'b0;
          mPh[c] = 0;
        end else if (eop) begin
          go     = (nP >= 2);
          mPh[c] = 0;
        end else begin
          go     = 1'b1;
          mPh[c] = mPh[c] + 1;
        end
        mRun[c] = go;
        mP[c]   = nP;
        mH[c]   = nH;
        if (app) mPend[c] = 1'b0;
        if (bus.load[c]) begin
          mSP[c]   = int'(bus.period_in[c*W +: W]);
          mSH[c]   = int'(bus.high_in[c*W +: W]);
          mPend[c] = 1'b1;
        end
      end
    end
  end

  // Compare process: on every falling edge the DUT outputs must match what
  // the model's phase implies.
  always @(negedge clock) begin
    if (modelValid) begin
      logic [NCH-1:0] expClk;
      logic [NCH-1:0] expTick;
      logic [NCH-1:0] expPend;
      for (int c = 0; c < NCH; c++) begin
        expClk[c]  = mRun[c] && (mPh[c] < mH[c]);
        expTick[c] = mRun[c] && (mPh[c] == mP[c] - 1);
        expPend[c] = mPend[c];
      end
      checkOutput("model clk_out", bus.clk_out, expClk);
      checkOutput("model tick", bus.tick, expTick);
      checkOutput("model pending", bus.pending, expPend);
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    int guard;
    bus.en        = '0;
    bus.sync      = 1'b0;
    bus.load      = '0;
    bus.period_in = '0;
    bus.high_in   = '0;

    // Reset defaults: P=2, H=1 on ch0 gives 1,0,1,0 with tick on the low cycles.
    applyStimulus(2);
    checkOutput("reset clk_out", bus.clk_out, 4'b0000);
    checkOutput("reset tick", bus.tick, 4'b0000);
    checkOutput("reset pending", bus.pending, 4'b0000);
    reset  = 1'b1;
    bus.en = 4'b0001;
    applyStimulus(1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus(1);
      checkBit("default clk0", bus.clk_out[0], (k % 2) == 0);
      checkBit("default tick0", bus.tick[0], (k % 2) == 1);
      checkOutput("default idle clk", {1'b0, bus.clk_out[3:1]}, 4'b0000);
      checkOutput("default idle tick", {1'b0, bus.tick[3:1]}, 4'b0000);
      checkOutput("default pending", bus.pending, 4'b0000);
    end

    // Deferred reload on ch0: P=5, H=2 waits for the next wrap.
    setLoad(0, 5, 2);
    applyStimulus(1);
    bus.load = '0;
    checkBit("reload pending a", bus.pending[0], 1'b1);
    applyStimulus(1);
    checkBit("reload pending b", bus.pending[0], 1'b1);
    checkBit("reload old tick", bus.tick[0], 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1);
      checkBit("reload clk0", bus.clk_out[0], (k % 5) < 2);
      checkBit("reload tick0", bus.tick[0], (k % 5) == 4);
      checkBit("reload pending0", bus.pending[0], 1'b0);
    end

    // Duty extremes on ch1: H=7 > P=4 holds clk high, H=0 holds it low.
    setLoad(1, 4, 7);
    applyStimulus(1);
    bus.load = '0;
    applyStimulus(1);
    checkBit("idle apply pending1", bus.pending[1], 1'b0);
    bus.en = 4'b0011;
    applyStimulus(1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) applyStimulus(1);
      checkBit("H>=P clk1", bus.clk_out[1], 1'b1);
      checkBit("H>=P tick1", bus.tick[1], (k % 4) == 3);
    end
    setLoad(1, 4, 0);
    applyStimulus(1);
    bus.load = '0;
    applyStimulus(3);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1);
      checkBit("H=0 clk1", bus.clk_out[1], 1'b0);
      checkBit("H=0 tick1", bus.tick[1], (k % 4) == 3);
    end

    // Phase sync: ch0 P=5 at phase 3, ch1 P=3 at phase 1.
    setLoad(1, 3, 1);
    applyStimulus(1);
    bus.load = '0;
    guard = 0;
    while (mPend[1] && guard < 20) begin
      applyStimulus(1);
      guard++;
    end
    expectWait("ch1 apply", guard < 20);
    guard = 0;
    while (!(mPh[0] == 3 && mPh[1] == 1) && guard < 40) begin
      applyStimulus(1);
      guard++;
    end
    expectWait("sync align", guard < 40);
    bus.sync = 1'b1;
    applyStimulus(1);
    bus.sync = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) applyStimulus(1);
      checkBit("sync clk0", bus.clk_out[0], (k % 5) < 2);
      checkBit("sync tick0", bus.tick[0], (k % 5) == 4);
      checkBit("sync clk1", bus.clk_out[1], (k % 3) < 1);
      checkBit("sync tick1", bus.tick[1], (k % 3) == 2);
    end

    // Sync with a concurrent load: the older shadow is applied, the new one waits.
    guard = 0;
    while (!(mPh[0] == 2 && mPh[1] == 0) && guard < 40) begin
      applyStimulus(1);
      guard++;
    end
    expectWait("sync2 align", guard < 40);
    setLoad(0, 4, 1);
    applyStimulus(1);
    bus.load = '0;
    checkBit("pre-sync pending0", bus.pending[0], 1'b1);
    bus.sync = 1'b1;
    setLoad(0, 6, 3);
    applyStimulus(1);
    bus.sync = 1'b0;
    bus.load = '0;
    checkBit("sync+load pending0", bus.pending[0], 1'b1);
    checkOutput("sync+load clk", {2'b00, bus.clk_out[1:0]}, 4'b0011);
    checkOutput("sync+load tick", {2'b00, bus.tick[1:0]}, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1);
      checkBit("old shadow clk0", bus.clk_out[0], k == 4);
      checkBit("old shadow tick0", bus.tick[0], k == 3);
      checkBit("old shadow pending0", bus.pending[0], k < 4);
    end

    // Invalid ratio on ch1, then a valid restart with P=3, H=1.
    setLoad(1, 1, 0);
    applyStimulus(1);
    bus.load = '0;
    guard = 0;
    while (mRun[1] && guard < 10) begin
      applyStimulus(1);
      guard++;
    end
    expectWait("invalid stop", guard < 10);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkBit("invalid clk1", bus.clk_out[1], 1'b0);
      checkBit("invalid tick1", bus.tick[1], 1'b0);
      checkBit("invalid pending1", bus.pending[1], 1'b0);
    end
    setLoad(1, 3, 1);
    applyStimulus(1);
    bus.load = '0;
    checkBit("restart pending a", bus.pending[1], 1'b1);
    checkBit("restart clk a", bus.clk_out[1], 1'b0);
    applyStimulus(1);
    checkBit("restart pending b", bus.pending[1], 1'b0);
    checkBit("restart clk b", bus.clk_out[1], 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1);
      checkBit("restart clk1", bus.clk_out[1], (k % 3) == 0);
      checkBit("restart tick1", bus.tick[1], (k % 3) == 2);
    end

    // Drop en on ch1 for one cycle at count 2, then restart from 0.
    bus.en[1] = 1'b0;
    applyStimulus(1);
    checkBit("en drop clk1", bus.clk_out[1], 1'b0);
    checkBit("en drop tick1", bus.tick[1], 1'b0);
    bus.en[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1);
      checkBit("en back clk1", bus.clk_out[1], k == 0);
      checkBit("en back tick1", bus.tick[1], k == 2);
    end

    // Reset pulse mid-period clears outputs and pending.
    setLoad(0, 7, 3);
    applyStimulus(1);
    bus.load = '0;
    checkBit("pre-reset pending0", bus.pending[0], 1'b1);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("mid reset clk_out", bus.clk_out, 4'b0000);
    checkOutput("mid reset tick", bus.tick, 4'b0000);
    checkOutput("mid reset pending", bus.pending, 4'b0000);

    // All channels running, including the largest legal ratio.
    reset  = 1'b1;
    bus.en = 4'b1111;
    setLoad(2, 3, 2);
    setLoad(3, 32'h0FFF_FFFF, 32'h0800_0000);
    applyStimulus(1);
    bus.load = '0;
    applyStimulus(20);
    bus.sync = 1'b1;
    applyStimulus(1);
    bus.sync = 1'b0;
    applyStimulus(20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/prescaler_multi.md
Name: prescaler_multi

Overview:
- Parametrised multi-channel clock prescaler. Successor to the single-channel toggle prescaler.
- Each channel divides the system clock by a programmable ratio and has programmable high time (duty).
- New settings are double-buffered and applied glitch-free at period boundaries. A global sync input phase-aligns all channels, and each channel emits an end-of-period tick.
- Feeds slow enables/clocks to peripheral logic in the FPGA fabric.

Parameters:
- NCH, 4, number of independent channels
- WIDTH, 28, bit width of the period and high-time values
- RESET_DIV, 2, period loaded into active and shadow registers at reset; high time resets to RESET_DIV/2

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-low reset
- en  input  NCH  per-channel run enable
- sync  input  1  one-cycle pulse; restarts all running channels at count 0
- load  input  NCH  one-cycle pulse; captures that channel's period_in/high_in slice into its shadow registers
- period_in  input  NCH*WIDTH  division ratio P per channel; channel i uses bits [i*WIDTH +: WIDTH]
- high_in  input  NCH*WIDTH  high time H per channel in clock cycles, same slicing
- clk_out  output  NCH  divided clock per channel, registered
- tick  output  NCH  one-cycle pulse on the last cycle of each period, registered
- pending  output  NCH  shadow holds values not yet applied

Behaviour:
- Reset is synchronous and active-low. While reset==0 at an edge:
  - cnt=0, clk_out=0, tick=0, pending=0, state=IDLE.
  - Active and shadow P=RESET_DIV, H=RESET_DIV/2.
- Per-channel state machine:
  - IDLE to RUN: on an edge with en=1 and active P>=2 ("start edge"). Then cnt<=0, clk_out<=(H>0), tick<=0.
  - RUN: each edge does cnt<=(cnt==P-1)?0:cnt+1. clk_out and tick are registered from the new cnt value, so in RUN clk_out==(cnt<H) and tick==(cnt==P-1) hold every cycle.
  - RUN to IDLE: en=0 at an edge. Then cnt<=0, clk_out<=0, tick<=0, the same edge.
  - Invalid ratio: an apply that makes P<2 forces the channel into IDLE with outputs 0. It stays in IDLE until a valid P is applied and en=1.
- Duty rules:
  - H>=P: clk_out constant 1 in RUN.
  - H=0: clk_out constant 0.
  - tick keeps period P in both cases.
- Shadow and apply:
  - load[i] at an edge: shadow_i<=slices, pending_i<=1.
  - An apply copies shadow to active and clears pending. Apply occurs:
    - in IDLE, on any edge with pending=1;
    - in RUN, on the edge where cnt wraps P-1 to 0, or on a sync edge.
  - The cycle after an apply in RUN runs with cnt=0 and the new P/H. Outputs use the new H immediately.
  - load concurrent with apply: the apply uses the pre-edge shadow, the new values enter the shadow, and pending stays 1.
- sync:
  - Every channel in RUN gets cnt<=0, any pending shadow is applied, tick<=0, clk_out<=(H_new>0).
  - IDLE channels are unaffected, apart from their normal IDLE apply.
  - sync coinciding with wrap behaves identically to wrap alone.
- Arithmetic:
  - Unsigned WIDTH-bit compares; no overflow, since cnt<=P-1<=2^WIDTH-2.
  - P=2^WIDTH-1 is legal.
- Channels are fully independent except for the shared sync and reset.
- No combinational path from any input to any output.

Test Plan:
- Reset defaults (NCH=4, WIDTH=28, RESET_DIV=2):
  - reset low 2 cycles, release, en=1 on ch0 only -> ch0 clk_out 1,0,1,0…
  - tick high on every clk_out=0 cycle; ch1-3 clk_out/tick stay 0; pending=0.
- Deferred reload:
  - ch0 running P=2; pulse load with P=5, H=2 mid-period -> pending=1 until the next wrap.
  - Then clk_out pattern 1,1,0,0,0 repeating, tick on the 5th cycle, pending=0.
- Duty extremes:
  - H=7 with P=4 -> clk_out constant 1, tick every 4 cycles.
  - H=0 -> clk_out constant 0, tick every 4 cycles.
- Phase sync:
  - ch0 P=5 at cnt=3 and ch1 P=3 at cnt=1; pulse sync -> both cnt=0, clk_out=1 next cycle.
  - ticks thereafter coincide every 15 cycles.
  - repeat with load issued the same cycle as sync -> old shadow applied, pending remains 1.
- Invalid ratio and restart:
  - load P=1 in RUN -> at wrap, channel goes IDLE with clk_out=0 and tick=0.
  - load P=3, H=1 with en=1 -> applied next edge, start edge follows, pattern 1,0,0.
- Enable/reset mid-operation:
  - drop en for one cycle at cnt=2 -> outputs 0 that cycle, restart from cnt=0.
  - reset low one cycle mid-period -> all outputs 0 and pending 0 the following cycle.
